// File: rtl/shift_arbiter.sv
// shift_arbiter: two requesters share one registered shift unit. Results return
// through a 2-entry response FIFO in acceptance order. Issue is throttled so that
// every in-flight result always has a FIFO slot waiting for it.
// Build option: define SHIFT_ARB_RR_EN for round-robin arbitration; without it
// requester 0 has fixed priority.
module shift_arbiter (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req0_valid,
  output logic        o_req0_ready,
  input  logic [31:0] i_req0_opA,
  input  logic [31:0] i_req0_opB,
  input  logic [2:0]  i_req0_type,
  input  logic        i_req1_valid,
  output logic        o_req1_ready,
  input  logic [31:0] i_req1_opA,
  input  logic [31:0] i_req1_opB,
  input  logic [2:0]  i_req1_type,
  output logic [31:0] o_su_opA,
  output logic [31:0] o_su_opB,
  output logic [2:0]  o_su_type,
  input  logic [31:0] i_su_result,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic        o_rsp_id,
  output logic [31:0] o_rsp_data
);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ACTIVE,
    ST_FULL
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  count;
  logic [1:0]  count_nxt;
  logic [2:0]  occupancy_nxt;
  logic        wr_ptr;
  logic        rd_ptr;
  logic        s1_vld;
  logic        s1_id;
  logic [32:0] fifo_mem [2];
  logic        prefer1;
  logic        push;
  logic        pop;
  logic        issue_ok;
  logic        grant1;
  logic        accept;

`ifdef SHIFT_ARB_RR_EN
  logic rr_ptr;

  // Round-robin pointer: after serving requester k, prefer the other one.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rr_ptr <= 1'b0;
    end else if (accept) begin
      rr_ptr <= !grant1;
    end
  end

  assign prefer1 = rr_ptr;
`else
  assign prefer1 = 1'b0;
`endif

  // State register: occupancy bookkeeping, FIFO pointers and stage-1 tracking.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= ST_EMPTY;
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      s1_vld <= 1'b0;
      s1_id  <= 1'b0;
    end else begin
      state  <= state_nxt;
      count  <= count_nxt;
      s1_vld <= accept;
      s1_id  <= grant1;
      if (push) begin
        wr_ptr <= !wr_ptr;
      end
      if (pop) begin
        rd_ptr <= !rd_ptr;
      end
    end
  end

  // FIFO storage: capture the shift result one cycle after its issue.
  always_ff @(posedge i_clk) begin
    if (!i_rst && push) begin
      fifo_mem[wr_ptr] <= {s1_id, i_su_result};
    end
  end

  // Next state: FULL whenever buffered plus in-flight results fill both slots.
  always_comb begin
    push          = s1_vld;
    count_nxt     = count + {1'b0, push} - {1'b0, pop};
    occupancy_nxt = {1'b0, count_nxt} + {2'b00, accept};
    state_nxt     = ST_ACTIVE;
    if (occupancy_nxt == 3'd0) begin
      state_nxt = ST_EMPTY;
    end else if (occupancy_nxt >= 3'd2) begin
      state_nxt = ST_FULL;
    end
  end

  // Outputs: response head, issue permission, grant and shift-unit operands.
  always_comb begin
    o_rsp_valid  = !i_rst && (count != 2'd0);
    o_rsp_id     = 1'b0;
    o_rsp_data   = 32'd0;
    if (o_rsp_valid) begin
      o_rsp_id   = fifo_mem[rd_ptr][32];
      o_rsp_data = fifo_mem[rd_ptr][31:0];
    end
    pop          = o_rsp_valid && i_rsp_ready;
    issue_ok     = !i_rst && ((state != ST_FULL) || pop);
    grant1       = i_req1_valid && (!i_req0_valid || prefer1);
    o_req0_ready = issue_ok && i_req0_valid && !grant1;
    o_req1_ready = issue_ok && grant1;
    accept       = (i_req0_valid && o_req0_ready) || (i_req1_valid && o_req1_ready);
    o_su_opA     = 32'd0;
    o_su_opB     = 32'd0;
    o_su_type    = 3'd0;
    if (accept) begin
      if (grant1) begin
        o_su_opA  = i_req1_opA;
        o_su_opB  = {27'd0, i_req1_opB[4:0]};
        o_su_type = i_req1_type;
      end else begin
        o_su_opA  = i_req0_opA;
        o_su_opB  = {27'd0, i_req0_opB[4:0]};
        o_su_type = i_req0_type;
      end
    end
  end

  // A push into a full FIFO without a simultaneous pop must never happen.
  a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
    !(push && !pop && (count == 2'd2)));

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed testbench for shift_arbiter, including a registered shift-unit model.
// Expected arbitration order depends on whether SHIFT_ARB_RR_EN is defined.
module tb_shift_arbiter;

  logic        i_clk;
  logic        i_rst;
  logic        i_req0_valid;
  logic        o_req0_ready;
  logic [31:0] i_req0_opA;
  logic [31:0] i_req0_opB;
  logic [2:0]  i_req0_type;
  logic        i_req1_valid;
  logic        o_req1_ready;
  logic [31:0] i_req1_opA;
  logic [31:0] i_req1_opB;
  logic [2:0]  i_req1_type;
  logic [31:0] o_su_opA;
  logic [31:0] o_su_opB;
  logic [2:0]  o_su_type;
  logic [31:0] i_su_result;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic        o_rsp_id;
  logic [31:0] o_rsp_data;

  int total;
  int bad;

  shift_arbiter dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_req0_valid (i_req0_valid),
    .o_req0_ready (o_req0_ready),
    .i_req0_opA   (i_req0_opA),
    .i_req0_opB   (i_req0_opB),
    .i_req0_type  (i_req0_type),
    .i_req1_valid (i_req1_valid),
    .o_req1_ready (o_req1_ready),
    .i_req1_opA   (i_req1_opA),
    .i_req1_opB   (i_req1_opB),
    .i_req1_type  (i_req1_type),
    .o_su_opA     (o_su_opA),
    .o_su_opB     (o_su_opB),
    .o_su_type    (o_su_type),
    .i_su_result  (i_su_result),
    .o_rsp_valid  (o_rsp_valid),
    .i_rsp_ready  (i_rsp_ready),
    .o_rsp_id     (o_rsp_id),
    .o_rsp_data   (o_rsp_data)
  );

  // Clock: rising edges at 5, 15, 25, ...
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Registered shift unit: SLL for type 0, SRL for type 1, SRA otherwise.
  always @(posedge i_clk) begin
    case (o_su_type)
      3'd0:    i_su_result <= o_su_opA << o_su_opB[4:0];
      3'd1:    i_su_result <= o_su_opA >> o_su_opB[4:0];
      default: i_su_result <= $unsigned($signed(o_su_opA) >>> o_su_opB[4:0]);
    endcase
  end

  // Safety net in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  task automatic idle_inputs();
    i_req0_valid = 1'b0;
    i_req0_opA   = 32'd0;
    i_req0_opB   = 32'd0;
    i_req0_type  = 3'd0;
    i_req1_valid = 1'b0;
    i_req1_opA   = 32'd0;
    i_req1_opB   = 32'd0;
    i_req1_type  = 3'd0;
  endtask

  task automatic reset_dut();
    @(negedge i_clk);
    idle_inputs();
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge i_clk);
    i_rst        = 1'b1;
    i_rsp_ready  = 1'b1;
    i_req0_valid = 1'b1;
    i_req0_opA   = 32'h1234_5678;
    i_req0_opB   = 32'd3;
    i_req1_valid = 1'b1;
    i_req1_opA   = 32'h8765_4321;
    @(negedge i_clk);
    @(negedge i_clk);
    #1;
    total++; if (o_req0_ready !== 1'b0) begin bad++; $display("[TB] FAIL rst_ready0 got=%0h exp=0", o_req0_ready); end
    total++; if (o_req1_ready !== 1'b0) begin bad++; $display("[TB] FAIL rst_ready1 got=%0h exp=0", o_req1_ready); end
    total++; if (o_rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_rsp_valid got=%0h exp=0", o_rsp_valid); end
    total++; if (o_rsp_id !== 1'b0) begin bad++; $display("[TB] FAIL rst_rsp_id got=%0h exp=0", o_rsp_id); end
    total++; if (o_rsp_data !== 32'd0) begin bad++; $display("[TB] FAIL rst_rsp_data got=%h exp=0", o_rsp_data); end
    total++; if (o_su_opA !== 32'd0) begin bad++; $display("[TB] FAIL rst_su_opA got=%h exp=0", o_su_opA); end
    total++; if (o_su_opB !== 32'd0) begin bad++; $display("[TB] FAIL rst_su_opB got=%h exp=0", o_su_opB); end
    total++; if (o_su_type !== 3'd0) begin bad++; $display("[TB] FAIL rst_su_type got=%0h exp=0", o_su_type); end
    @(negedge i_clk);
    idle_inputs();
    i_rst = 1'b0;
    #1;
    total++; if (o_rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL post_rst_rsp_valid got=%0h exp=0", o_rsp_valid); end
    total++; if (o_su_opA !== 32'd0) begin bad++; $display("[TB] FAIL post_rst_su_opA got=%h exp=0", o_su_opA); end
  endtask

  task automatic test_masked_shift();
    reset_dut();
    i_rsp_ready = 1'b1;
    @(negedge i_clk);
    i_req0_valid = 1'b1;
    i_req0_opA   = 32'h0000_0001;
    i_req0_opB   = 32'h0000_0024;
    i_req0_type  = 3'd0;
    #1;
    total++; if (o_req0_ready !== 1'b1) begin bad++; $display("[TB] FAIL mask_ready0 got=%0h exp=1", o_req0_ready); end
    total++; if (o_su_opA !== 32'h1) begin bad++; $display("[TB] FAIL mask_su_opA got=%h exp=1", o_su_opA); end
    total++; if (o_su_opB !== 32'h4) begin bad++; $display("[TB] FAIL mask_su_opB got=%h exp=4", o_su_opB); end
    @(negedge i_clk);
    idle_inputs();
    #1;
    total++; if (o_rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL mask_t1_valid got=%0h exp=0", o_rsp_valid); end
    total++; if (o_su_opA !== 32'd0) begin bad++; $display("[TB] FAIL mask_idle_su got=%h exp=0", o_su_opA); end
    @(negedge i_clk);
    #1;
    total++; if (o_rsp_valid !== 1'b1) begin bad++; $display("[TB] FAIL mask_t2_valid got=%0h exp=1", o_rsp_valid); end
    total++; if (o_rsp_id !== 1'b0) begin bad++; $display("[TB] FAIL mask_t2_id got=%0h exp=0", o_rsp_id); end
    total++; if (o_rsp_data !== 32'h10) begin bad++; $display("[TB] FAIL mask_t2_data got=%h exp=10", o_rsp_data); end
    @(negedge i_clk);
    #1;
    total++; if (o_rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL mask_t3_valid got=%0h exp=0", o_rsp_valid); end
  endtask

  task automatic test_arbitration();
    logic exp_id [4];
`ifdef SHIFT_ARB_RR_EN
    exp_id = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_id = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    reset_dut();
    i_rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge i_clk);
      if (i < 4) begin
        i_req0_valid = 1'b1;
        i_req0_opA   = 32'h0000_0011;
        i_req1_valid = 1'b1;
        i_req1_opA   = 32'h0000_0022;
      end else begin
        idle_inputs();
      end
      #1;
      if (i < 4) begin
        total++; if (o_req1_ready !== exp_id[i]) begin bad++; $display("[TB] FAIL arb_ready1[%0d] got=%0h exp=%0h", i, o_req1_ready, exp_id[i]); end
        total++; if (o_req0_ready !== !exp_id[i]) begin bad++; $display("[TB] FAIL arb_ready0[%0d] got=%0h exp=%0h", i, o_req0_ready, !exp_id[i]); end
      end
      if (i >= 2) begin
        total++; if (o_rsp_valid !== 1'b1) begin bad++; $display("[TB] FAIL arb_rsp_valid[%0d] got=%0h exp=1", i, o_rsp_valid); end
        total++; if (o_rsp_id !== exp_id[i-2]) begin bad++; $display("[TB] FAIL arb_rsp_id[%0d] got=%0h exp=%0h", i, o_rsp_id, exp_id[i-2]); end
        total++; if (o_rsp_data !== (exp_id[i-2] ? 32'h22 : 32'h11)) begin bad++; $display("[TB] FAIL arb_rsp_data[%0d] got=%h exp=%h", i, o_rsp_data, exp_id[i-2] ? 32'h22 : 32'h11); end
      end
    end
  endtask

  task automatic test_type_select();
    reset_dut();
    i_rsp_ready = 1'b1;
    @(negedge i_clk);
    i_req1_valid = 1'b1;
    i_req1_opA   = 32'h8000_0000;
    i_req1_opB   = 32'd31;
    i_req1_type  = 3'd1;
    #1;
    total++; if (o_req1_ready !== 1'b1) begin bad++; $display("[TB] FAIL type_ready_srl got=%0h exp=1", o_req1_ready); end
    @(negedge i_clk);
    i_req1_type = 3'd2;
    #1;
    total++; if (o_req1_ready !== 1'b1) begin bad++; $display("[TB] FAIL type_ready_sra got=%0h exp=1", o_req1_ready); end
    total++; if (o_su_type !== 3'd2) begin bad++; $display("[TB] FAIL type_su_type got=%0h exp=2", o_su_type); end
    @(negedge i_clk);
    idle_inputs();
    #1;
    total++; if (o_rsp_id !== 1'b1) begin bad++; $display("[TB] FAIL type_srl_id got=%0h exp=1", o_rsp_id); end
    total++; if (o_rsp_data !== 32'h0000_0001) begin bad++; $display("[TB] FAIL type_srl_data got=%h exp=00000001", o_rsp_data); end
    @(negedge i_clk);
    #1;
    total++; if (o_rsp_id !== 1'b1) begin bad++; $display("[TB] FAIL type_sra_id got=%0h exp=1", o_rsp_id); end
    total++; if (o_rsp_data !== 32'hFFFF_FFFF) begin bad++; $display("[TB] FAIL type_sra_data got=%h exp=ffffffff", o_rsp_data); end
  endtask

  task automatic test_backpressure();
    reset_dut();
    i_rsp_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge i_clk);
      i_req0_valid = (i < 6);
      i_req0_opA   = (i == 0) ? 32'hA1 : (i == 1) ? 32'hA2 : 32'hA3;
      i_rsp_ready  = (i >= 5);
      #1;
      if (i < 2 || i == 5) begin
        total++; if (o_req0_ready !== 1'b1) begin bad++; $display("[TB] FAIL bp_ready_hi[%0d] got=%0h exp=1", i, o_req0_ready); end
      end
      if (i >= 2 && i <= 4) begin
        total++; if (o_req0_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_ready_lo[%0d] got=%0h exp=0", i, o_req0_ready); end
        total++; if (o_rsp_data !== 32'hA1) begin bad++; $display("[TB] FAIL bp_hold_data[%0d] got=%h exp=a1", i, o_rsp_data); end
      end
      if (i >= 5) begin
        total++; if (o_rsp_valid !== 1'b1) begin bad++; $display("[TB] FAIL bp_drain_valid[%0d] got=%0h exp=1", i, o_rsp_valid); end
        total++; if (o_rsp_data !== (32'hA1 + 32'(i - 5))) begin bad++; $display("[TB] FAIL bp_drain_data[%0d] got=%h exp=%h", i, o_rsp_data, 32'hA1 + 32'(i - 5)); end
      end
    end
    @(negedge i_clk);
    #1;
    total++; if (o_rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_empty got=%0h exp=0", o_rsp_valid); end
  endtask

  task automatic test_reset_midflight();
    reset_dut();
    i_rsp_ready = 1'b1;
    @(negedge i_clk);
    i_req0_valid = 1'b1;
    i_req0_opA   = 32'h5;
    i_req0_opB   = 32'd1;
    #1;
    total++; if (o_req0_ready !== 1'b1) begin bad++; $display("[TB] FAIL mid_accept got=%0h exp=1", o_req0_ready); end
    @(negedge i_clk);
    idle_inputs();
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (o_rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL mid_ghost[%0d] got=%0h exp=0", i, o_rsp_valid); end
      @(negedge i_clk);
    end
    i_req1_valid = 1'b1;
    i_req1_opA   = 32'h3;
    i_req1_opB   = 32'd2;
    #1;
    total++; if (o_req1_ready !== 1'b1) begin bad++; $display("[TB] FAIL mid_post_ready got=%0h exp=1", o_req1_ready); end
    @(negedge i_clk);
    idle_inputs();
    @(negedge i_clk);
    #1;
    total++; if (o_rsp_valid !== 1'b1) begin bad++; $display("[TB] FAIL mid_post_valid got=%0h exp=1", o_rsp_valid); end
    total++; if (o_rsp_id !== 1'b1) begin bad++; $display("[TB] FAIL mid_post_id got=%0h exp=1", o_rsp_id); end
    total++; if (o_rsp_data !== 32'hC) begin bad++; $display("[TB] FAIL mid_post_data got=%h exp=c", o_rsp_data); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_data [8];
    exp_data = '{32'h1, 32'h4, 32'hC, 32'h20, 32'h50, 32'hC0, 32'h1C0, 32'h400};
    reset_dut();
    i_rsp_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      @(negedge i_clk);
      if (i < 8) begin
        i_req0_valid = 1'b1;
        i_req0_opA   = 32'(i + 1);
        i_req0_opB   = 32'(i);
      end else begin
        idle_inputs();
      end
      #1;
      if (i < 8) begin
        total++; if (o_req0_ready !== 1'b1) begin bad++; $display("[TB] FAIL b2b_ready[%0d] got=%0h exp=1", i, o_req0_ready); end
      end
      if (i >= 2 && i < 10) begin
        total++; if (o_rsp_valid !== 1'b1) begin bad++; $display("[TB] FAIL b2b_valid[%0d] got=%0h exp=1", i, o_rsp_valid); end
        total++; if (o_rsp_data !== exp_data[i-2]) begin bad++; $display("[TB] FAIL b2b_data[%0d] got=%h exp=%h", i, o_rsp_data, exp_data[i-2]); end
      end
      if (i == 10) begin
        total++; if (o_rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL b2b_drained got=%0h exp=0", o_rsp_valid); end
      end
    end
  endtask

  // Main sequence: run each scenario in turn, then report.
  initial begin
    total       = 0;
    bad         = 0;
    i_rst       = 1'b1;
    i_rsp_ready = 1'b0;
    idle_inputs();
    test_reset();
    test_masked_shift();
    test_arbitration();
    test_type_select();
    test_backpressure();
    test_reset_midflight();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_arbiter.md
SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 The block SHALL have these ports: i_clk  in  1  sole clock, all state on rising edge.
REQ-002 i_rst  in  1  reset, synchronous, active-high.
REQ-003 i_req0_valid / o_req0_ready  in/out  1  requester-0 handshake; i_req0_opA, i_req0_opB  in  32  operands; i_req0_type  in  3  shift type.
REQ-004 i_req1_valid / o_req1_ready / i_req1_opA / i_req1_opB / i_req1_type: the same set for requester 1.
REQ-005 o_su_opA, o_su_opB  out  32 and o_su_type  out  3: operands to the shared registered shift unit.
REQ-006 i_su_result  in  32: shift-unit result, valid one cycle after its operands are presented.
REQ-007 o_rsp_valid  out  1, i_rsp_ready  in  1, o_rsp_id  out  1 (requester index), o_rsp_data  out  32: response channel.

Function
REQ-008 A request SHALL be accepted in cycle T when valid&&ready are both high for it; at most one acceptance per cycle.
REQ-009 Issue permission SHALL be: fifo_count + s1_vld - (o_rsp_valid&&i_rsp_ready) < 2; ready SHALL go only to the granted requester, and only when issue is permitted.
REQ-010 Grant with one valid requester: that requester. With both valid: arbitration per REQ-026/027.
REQ-011 On acceptance: o_su_opA = granted opA; o_su_opB = {27'b0, opB[4:0]}; o_su_type passed through unchanged (OP0=SLL, OP1=SRL, others=SRA).
REQ-012 With no acceptance, o_su_opA/opB/type SHALL be driven to zero.
REQ-013 Stage-1 tracking: s1_vld<=accept, s1_id<=granted index, captured at the end of T.
REQ-014 In T+1, if s1_vld, {s1_id, i_su_result} SHALL be pushed into a 2-entry response FIFO at the end of that cycle.
REQ-015 o_rsp_valid = FIFO non-empty; o_rsp_id/o_rsp_data = FIFO head; pop on o_rsp_valid&&i_rsp_ready.
REQ-016 Minimum accept-to-response latency SHALL be 2 cycles (response visible in T+2).
REQ-017 Sustained throughput with i_rsp_ready=1 SHALL be one request per cycle.
REQ-018 Simultaneous push and pop with the FIFO full SHALL pop first and push second: count unchanged, order preserved.
REQ-019 The FIFO SHALL never overflow; a push into a full FIFO without a pop is unreachable and SHALL be asserted in simulation.
REQ-020 Responses SHALL leave in acceptance order; o_rsp_id/o_rsp_data SHALL be held stable while o_rsp_valid&&!i_rsp_ready.
REQ-021 FIFO pointers SHALL be 1 bit and wrap modulo 2; count SHALL be 2 bits, range 0..2.
REQ-022 Control state SHALL be: EMPTY (count=0, !s1_vld), ACTIVE (otherwise, issue permitted), FULL (issue not permitted).
- Transitions follow count and s1_vld each cycle.
- FULL exits as soon as a pop is credited.

Reset
REQ-023 While i_rst=1 at a clock edge: s1_vld=0, FIFO empty, pointers=0, RR pointer=0 (req0 preferred).
REQ-024 During and immediately after reset: o_req*_ready=0, o_rsp_valid=0, o_rsp_id=0, o_rsp_data=0, o_su_*=0.
REQ-025 Reset mid-operation SHALL discard in-flight and buffered results; no response for them is ever emitted.

Configuration
REQ-026 With SHIFT_ARB_RR_EN defined: round-robin arbitration; after a grant to requester k, the pointer moves so that 1-k is preferred on the next conflict.
REQ-027 Without SHIFT_ARB_RR_EN: fixed priority, requester 0 always wins; no pointer register exists.

Verification
REQ-028 Req0 opA=0x0000_0001, opB=0x0000_0024, type=OP0 -> shift amount masked to 4; o_rsp_data=0x0000_0010, id=0, in T+2.
REQ-029 Both requesters valid for 4 cycles, rsp_ready=1 -> RR build: ids 0,1,0,1; fixed build: 0,0,0,0 with req1 starved.
REQ-030 Req1 opA=0x8000_0000, opB=31, type=OP1 then type=OP2 -> responses 0x0000_0001 then 0xFFFF_FFFF.
REQ-031 i_rsp_ready=0 with continuous valid -> exactly 2 accepts, then readies low; raise rsp_ready -> 2 responses in order, with issue resuming in the same cycle as the first pop.
REQ-032 Assert i_rst in the cycle after an accept -> no response ever appears; first post-reset request completes normally with id/data correct.
REQ-033 Back-to-back 8 requests, rsp_ready=1 -> 8 accepts in 8 consecutive cycles and 8 responses in 8 consecutive cycles.
